ysyx_24090003_dmem_resp: RTL and testbench

YSYX_24090003_DMEM_RESP -- requirements
Module: ysyx_24090003_DMEM_RESP

---
 rtl/ysyx_24090003_dmem_resp_if.sv | 23 ++
 rtl/ysyx_24090003_dmem_resp.sv | 159 +++++++++++++++
 tb/tb_ysyx_24090003_dmem_resp.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24090003_dmem_resp_if.sv
// rtl/ysyx_24090003_dmem_resp_if.sv - request/response handshake bundle for the data memory
interface ysyx_24090003_dmem_resp_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic        i_mem_we;
  logic [2:0]  i_mem_wmask;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport slave (
    input  i_req_valid, i_mem_addr, i_mem_wdata, i_mem_we, i_mem_wmask, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport master (
    output i_req_valid, i_mem_addr, i_mem_wdata, i_mem_we, i_mem_wmask, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/ysyx_24090003_dmem_resp.sv
// rtl/ysyx_24090003_dmem_resp.sv - fixed-latency data memory with byte/half/word access and fault reporting
module ysyx_24090003_dmem_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  ysyx_24090003_dmem_resp_if.slave       bus
);

  localparam int          AW        = $clog2(4 * DEPTH_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic          cur_we;
  logic [2:0]    cur_wmask;
  logic [31:0]   off;
  logic [AW-3:0] idx;
  logic [1:0]    lane;
  logic          fault;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_data;
  logic          wr_en;
  logic [3:0]    wr_be;
  logic [31:0]   wr_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (bus.i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_req_ready = (state_q == S_IDLE);
    bus.o_rsp_valid = (state_q == S_RESP);
    bus.o_rsp_rdata = rdata_q;
    bus.o_rsp_err   = err_q;
  end

  // With LATENCY = 1 the access resolves on the accept edge, so use the live request.
  always_comb begin
    accept     = (state_q == S_IDLE) && bus.i_req_valid;
    enter_resp = ((state_q == S_WAIT) && (cnt_q == 4'd0)) || (accept && (LATENCY == 1));
    cur_addr   = (state_q == S_IDLE) ? bus.i_mem_addr  : addr_q;
    cur_wdata  = (state_q == S_IDLE) ? bus.i_mem_wdata : wdata_q;
    cur_we     = (state_q == S_IDLE) ? bus.i_mem_we    : we_q;
    cur_wmask  = (state_q == S_IDLE) ? bus.i_mem_wmask : wmask_q;

    off  = cur_addr - BASE_ADDR;
    idx  = off[AW-1:2];
    lane = cur_addr[1:0];

    fault = ({1'b0, off} >= MEM_BYTES)
          || ((cur_wmask == 3'b010) && cur_addr[0])
          || ((cur_wmask == 3'b100) && (cur_addr[1:0] != 2'b00))
          || !((cur_wmask == 3'b001) || (cur_wmask == 3'b010) || (cur_wmask == 3'b100));

    rd_word  = mem[idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (cur_wmask)
      3'b001:  rd_data = {24'h0, rd_shift[7:0]};
      3'b010:  rd_data = {16'h0, rd_shift[15:0]};
      default: rd_data = rd_shift;
    endcase

    case (cur_wmask)
      3'b001: begin
        wr_be   = 4'b0001 << lane;
        wr_word = {4{cur_wdata[7:0]}};
      end
      3'b010: begin
        wr_be   = 4'b0011 << lane;
        wr_word = {2{cur_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_word = cur_wdata;
      end
    endcase
    wr_en = i_rst_n && enter_resp && cur_we && !fault;

    addr_d  = accept ? bus.i_mem_addr  : addr_q;
    wdata_d = accept ? bus.i_mem_wdata : wdata_q;
    we_d    = accept ? bus.i_mem_we    : we_q;
    wmask_d = accept ? bus.i_mem_wmask : wmask_q;
    rdata_d = enter_resp ? ((cur_we || fault) ? 32'h0 : rd_data) : rdata_q;
    err_d   = enter_resp ? fault : err_q;
  end

  // Storage has no reset so its contents survive i_rst_n.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24090003_dmem_resp.sv
// tb/tb_ysyx_24090003_dmem_resp.sv - directed self-checking bench for ysyx_24090003_dmem_resp
module tb_ysyx_24090003_dmem_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ysyx_24090003_dmem_resp_if bus ();

  ysyx_24090003_dmem_resp #(
    .BASE_ADDR  (32'h8000_0000),
    .DEPTH_WORDS(1024),
    .LATENCY    (2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic [2:0] m, output logic [31:0] rd, output logic er,
                        output int lat);
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_mem_addr  = a;
    bus.i_mem_wdata = wd;
    bus.i_mem_we    = we;
    bus.i_mem_wmask = m;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    lat = -1;
    rd  = 32'hFFFF_FFFF;
    er  = 1'bx;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_rsp_valid) lat = i;
    end
    if (lat > 0) begin
      rd = bus.o_rsp_rdata;
      er = bus.o_rsp_err;
      bus.i_rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.i_rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks += 4;
    if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.o_req_ready); end
    if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_rsp_valid); end
    if (bus.o_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.o_rsp_rdata); end
    if (bus.o_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.o_rsp_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic er; int lat;
    access(32'h8000_0010, 32'hDEADBEEF, 1'b1, 3'b100, rd, er, lat);
    n_checks += 3;
    if (lat !== 2) begin n_fail++; $display("FAIL wr_word_latency got %0d want 2", lat); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL wr_word_err got %b want 0", er); end
    if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_word_rdata got %h want 0", rd); end
    access(32'h8000_0010, 32'h0, 1'b0, 3'b100, rd, er, lat);
    n_checks += 3;
    if (lat !== 2) begin n_fail++; $display("FAIL rd_word_latency got %0d want 2", lat); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL rd_word_err got %b want 0", er); end
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_word_data got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic er; int lat;
    access(32'h8000_0012, 32'hAAAA_AA5A, 1'b1, 3'b001, rd, er, lat);
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL wr_byte_err got %b want 0", er); end
    access(32'h8000_0010, 32'h0, 1'b0, 3'b100, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDE5ABEEF) begin n_fail++; $display("FAIL rd_after_byte got %h want de5abeef", rd); end
    access(32'h8000_0012, 32'h0, 1'b0, 3'b010, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0000DE5A) begin n_fail++; $display("FAIL rd_half_12 got %h want 0000de5a", rd); end
    access(32'h8000_0013, 32'h0, 1'b0, 3'b001, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0000_00DE) begin n_fail++; $display("FAIL rd_byte_13 got %h want 000000de", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [5];
    logic [2:0]  masks [5];
    logic [31:0] exps  [5];
    logic [31:0] rd; logic er; int lat;
    addrs = '{32'h8000_0010, 32'h8000_0011, 32'h8000_0012, 32'h8000_0013, 32'h8000_0010};
    masks = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    exps  = '{32'h0000_00EF, 32'h0000_00BE, 32'h0000_005A, 32'h0000_00DE, 32'h0000_BEEF};
    for (int i = 0; i < 5; i++) begin
      access(addrs[i], 32'h0, 1'b0, masks[i], rd, er, lat);
      n_checks += 2;
      if (rd !== exps[i] || er !== 1'b0) begin
        n_fail++; $display("FAIL b2b_data[%0d] got %h err %b want %h err 0", i, rd, er, exps[i]);
      end
      if (lat !== 2) begin n_fail++; $display("FAIL b2b_latency[%0d] got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    bit seen;
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_mem_addr  = 32'h8000_0010;
    bus.i_mem_we    = 1'b0;
    bus.i_mem_wmask = 3'b100;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1 seen = bus.o_rsp_valid;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL bp_valid_timeout got 0 want 1"); end
    bus.i_req_valid = 1'b1;
    bus.i_mem_addr  = 32'h8000_0010;
    bus.i_mem_wdata = 32'h1234_5678;
    bus.i_mem_we    = 1'b1;
    bus.i_mem_wmask = 3'b100;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_rdata !== 32'hDE5ABEEF || bus.o_req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got valid %b rdata %h ready %b want 1 de5abeef 0",
                 c, bus.o_rsp_valid, bus.o_rsp_rdata, bus.o_req_ready);
      end
    end
    bus.i_req_valid = 1'b0;
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_rsp_ready = 1'b0;
    n_checks++;
    if (bus.o_rsp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got valid %b ready %b want 0 1", bus.o_rsp_valid, bus.o_req_ready);
    end
    access(32'h8000_0010, 32'h0, 1'b0, 3'b100, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDE5ABEEF) begin n_fail++; $display("FAIL bp_ignored_write got %h want de5abeef", rd); end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [6];
    logic        wes   [6];
    logic [2:0]  masks [6];
    logic [31:0] rd; logic er; int lat;
    addrs = '{32'h8000_0011, 32'h8000_0002, 32'h8000_1000, 32'h8000_1000, 32'h8000_0000, 32'h7FFF_FFFC};
    wes   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    masks = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b011, 3'b100};
    access(32'h8000_0000, 32'hA5A5_A5A5, 1'b1, 3'b100, rd, er, lat);
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL seed_write_err got %b want 0", er); end
    for (int i = 0; i < 6; i++) begin
      access(addrs[i], 32'hFFFF_FFFF, wes[i], masks[i], rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
        n_fail++; $display("FAIL fault[%0d] got err %b rdata %h lat %0d want 1 0 2", i, er, rd, lat);
      end
    end
    access(32'h8000_0002, 32'h1234_5678, 1'b1, 3'b100, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL fault_write got err %b rdata %h want 1 0", er, rd); end
    access(32'h8000_0000, 32'h0, 1'b0, 3'b100, rd, er, lat);
    n_checks++;
    if (rd !== 32'hA5A5_A5A5 || er !== 1'b0) begin
      n_fail++; $display("FAIL fault_no_commit got %h err %b want a5a5a5a5 0", rd, er);
    end
    access(32'h8000_0FFC, 32'h0BAD_F00D, 1'b1, 3'b100, rd, er, lat);
    access(32'h8000_0FFC, 32'h0, 1'b0, 3'b100, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin
      n_fail++; $display("FAIL last_word got %h err %b want 0badf00d 0", rd, er);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat;
    access(32'h8000_0020, 32'h5566_7788, 1'b1, 3'b100, rd, er, lat);
    access(32'h8000_0020, 32'h0, 1'b0, 3'b100, rd, er, lat);
    n_checks++;
    if (rd !== 32'h5566_7788) begin n_fail++; $display("FAIL rst_prior got %h want 55667788", rd); end
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_mem_addr  = 32'h8000_0020;
    bus.i_mem_wdata = 32'h1111_1111;
    bus.i_mem_we    = 1'b1;
    bus.i_mem_wmask = 3'b100;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    n_checks++;
    if (bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_wait got ready %b want 0", bus.o_req_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0 || bus.o_rsp_rdata !== 32'h0 || bus.o_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async got ready %b valid %b rdata %h err %b want 1 0 0 0",
               bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_rdata, bus.o_rsp_err);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid got %b want 0", bus.o_rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    access(32'h8000_0020, 32'h0, 1'b0, 3'b100, rd, er, lat);
    n_checks++;
    if (rd !== 32'h5566_7788 || er !== 1'b0 || lat !== 2) begin
      n_fail++; $display("FAIL rst_dropped_write got %h err %b lat %0d want 55667788 0 2", rd, er, lat);
    end
  endtask

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_mem_addr  = 32'h0;
    bus.i_mem_wdata = 32'h0;
    bus.i_mem_we    = 1'b0;
    bus.i_mem_wmask = 3'b100;
    bus.i_rsp_ready = 1'b0;
    test_reset();
    test_word_rw();
    test_byte_half();
    test_back_to_back();
    test_backpressure();
    test_faults();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
